// File: rtl/cordic_engine_if.sv
// Handshake bundle for cordic_engine: request side (i_*) and result side (o_*).
// Ports: i_mode/i_re/i_im/i_angle with i_valid/i_ready; o_re/o_im/o_angle with o_valid/o_ready.
// master = producer of requests and consumer of results; slave = the engine.
interface cordic_engine_if #(
  parameter int POINT_SZ = 16,
  parameter int ANGLE_SZ = 34
);
  logic                       i_mode;
  logic signed [POINT_SZ-1:0] i_re;
  logic signed [POINT_SZ-1:0] i_im;
  logic signed [ANGLE_SZ-1:0] i_angle;
  logic                       i_valid;
  logic                       i_ready;
  logic signed [POINT_SZ-1:0] o_re;
  logic signed [POINT_SZ-1:0] o_im;
  logic signed [ANGLE_SZ-1:0] o_angle;
  logic                       o_valid;
  logic                       o_ready;

  modport master (
    output i_mode, i_re, i_im, i_angle, i_valid, o_ready,
    input  i_ready, o_re, o_im, o_angle, o_valid
  );

  modport slave (
    input  i_mode, i_re, i_im, i_angle, i_valid, o_ready,
    output i_ready, o_re, o_im, o_angle, o_valid
  );
endinterface

// File: rtl/cordic_engine.sv
// Iterative CORDIC (rotation / vectoring) with quadrant pre-rotation, optional gain comp + saturation.
// Latency: accept to o_valid = ITERATIONS+2 cycles (GAIN_COMP=1), ITERATIONS+1 otherwise; no overlap.
// Backpressure: i_ready only in IDLE; result held in DONE until o_ready. Ports: clk, rst_n, bus (slave).
module cordic_engine #(
  parameter int POINT_SZ   = 16,
  parameter int ANGLE_SZ   = 34,
  parameter int ITERATIONS = 16,
  parameter int GAIN_COMP  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_engine_if.slave  bus
);
  localparam int XW  = POINT_SZ + 2;          // two guard bits for negation and CORDIC growth
  localparam int KW  = POINT_SZ + 1;          // fractional bits of K
  localparam int PW  = XW + KW + 1;
  localparam int KCW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  localparam logic signed [XW-1:0] P_MAX = {3'b000, {(POINT_SZ-1){1'b1}}};
  localparam logic signed [XW-1:0] P_MIN = {3'b111, {(POINT_SZ-1){1'b0}}};

  // Positive real to 64-bit integer, round to nearest; split to stay within $rtoi's 32 bits.
  function automatic logic [63:0] real_to_fix(input real a);
    real r;
    int  hi;
    int  lo;
    r  = a + 0.5;
    hi = $rtoi(r / 2147483648.0);
    lo = $rtoi(r - $itor(hi) * 2147483648.0);
    return (64'(hi) << 31) + 64'(lo);
  endfunction

  function automatic logic signed [ANGLE_SZ-1:0] atan_fix(input int k);
    return ANGLE_SZ'(real_to_fix($atan(1.0 / (2.0 ** $itor(k))) * (2.0 ** $itor(ANGLE_SZ-4))));
  endfunction

  function automatic logic [KW-1:0] k_fix();
    real kr;
    kr = 1.0;
    for (int i = 0; i < ITERATIONS; i++) kr = kr / $sqrt(1.0 + 1.0 / (4.0 ** $itor(i)));
    return KW'(real_to_fix(kr * (2.0 ** $itor(KW))));
  endfunction

  localparam logic signed [ANGLE_SZ-1:0] PI_FIX =
    ANGLE_SZ'(real_to_fix(3.14159265358979323846 * (2.0 ** $itor(ANGLE_SZ-4))));
  localparam logic signed [ANGLE_SZ-1:0] HALF_PI_FIX =
    ANGLE_SZ'(real_to_fix(1.57079632679489661923 * (2.0 ** $itor(ANGLE_SZ-4))));
  localparam logic [KW-1:0] K_FIX = k_fix();

  logic signed [ANGLE_SZ-1:0] atan_tab [ITERATIONS];
  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam logic signed [ANGLE_SZ-1:0] ATAN_G = atan_fix(g);
    assign atan_tab[g] = ATAN_G;
  end

  // x*K, round half away from zero on the magnitude.
  function automatic logic signed [XW-1:0] scale(input logic signed [XW-1:0] v);
    logic signed [PW-1:0] p;
    logic        [PW-1:0] m;
    logic signed [XW-1:0] r;
    p = PW'(v) * $signed(PW'(K_FIX));
    m = p[PW-1] ? -p : p;
    m = (m + (PW'(1) << (KW-1))) >> KW;
    r = XW'(m);
    return p[PW-1] ? -r : r;
  endfunction

  function automatic logic signed [POINT_SZ-1:0] sat(input logic signed [XW-1:0] v);
    if (v > P_MAX) return POINT_SZ'(P_MAX);
    if (v < P_MIN) return POINT_SZ'(P_MIN);
    return POINT_SZ'(v);
  endfunction

  typedef enum logic [2:0] {IDLE, PRE, ITER, SCALE, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       mode_q, mode_d;
  logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
  logic signed [ANGLE_SZ-1:0] z_q, z_d;
  logic [KCW-1:0]             k_q, k_d;
  logic                       i_ready_q, i_ready_d, o_valid_q, o_valid_d;
  logic signed [POINT_SZ-1:0] o_re_q, o_re_d, o_im_q, o_im_d;
  logic signed [ANGLE_SZ-1:0] o_angle_q, o_angle_d;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    k_d       = k_q;
    o_re_d    = o_re_q;
    o_im_d    = o_im_q;
    o_angle_d = o_angle_q;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        mode_d  = bus.i_mode;
        x_d     = XW'(bus.i_re);
        y_d     = XW'(bus.i_im);
        z_d     = bus.i_angle;
        state_d = PRE;
      end
      PRE: begin
        if (!mode_q) begin
          if (z_q > HALF_PI_FIX) begin
            z_d = z_q - PI_FIX; x_d = -x_q; y_d = -y_q;
          end else if (z_q < -HALF_PI_FIX) begin
            z_d = z_q + PI_FIX; x_d = -x_q; y_d = -y_q;
          end
        end else begin
          z_d = '0;
          if (x_q[XW-1]) begin
            x_d = -x_q; y_d = -y_q;
            z_d = y_q[XW-1] ? -PI_FIX : PI_FIX;
          end
        end
        k_d     = '0;
        state_d = ITER;
      end
      ITER: begin
        if (mode_q ? y_q[XW-1] : !z_q[ANGLE_SZ-1]) begin
          x_d = x_q - (y_q >>> k_q);
          y_d = y_q + (x_q >>> k_q);
          z_d = z_q - atan_tab[k_q];
        end else begin
          x_d = x_q + (y_q >>> k_q);
          y_d = y_q - (x_q >>> k_q);
          z_d = z_q + atan_tab[k_q];
        end
        // A zero vector has no phase; without this z would accumulate the whole atan table.
        if (mode_q && x_q == '0 && y_q == '0) z_d = z_q;
        k_d = k_q + KCW'(1);
        if (k_q == KCW'(ITERATIONS-1)) begin
          if (GAIN_COMP != 0) begin
            state_d = SCALE;
          end else begin
            o_re_d    = sat(x_d);
            o_im_d    = sat(y_d);
            o_angle_d = z_d;
            state_d   = DONE;
          end
        end
      end
      SCALE: begin
        o_re_d    = sat(scale(x_q));
        o_im_d    = sat(scale(y_q));
        o_angle_d = z_q;
        state_d   = DONE;
      end
      DONE: if (bus.o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    i_ready_d = (state_d == IDLE);
    o_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      k_q       <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_re_q    <= '0;
      o_im_q    <= '0;
      o_angle_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      k_q       <= k_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
      o_re_q    <= o_re_d;
      o_im_q    <= o_im_d;
      o_angle_q <= o_angle_d;
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_re    = o_re_q;
  assign bus.o_im    = o_im_q;
  assign bus.o_angle = o_angle_q;
endmodule
